// File: rtl/adder_bist.sv
// adder_bist: built-in self-test driver/checker for the combinational 8-bit
// add/subtract unit (A_in, B_in, Sel_in -> Rez_out[8:0]).
//
// A 16-bit Galois LFSR (right shift, taps 16'hB400) generates operands. Vector
// i drives A = lfsr[7:0], B = lfsr[15:8], Sel = i[0]. Each expected result is
// pushed into a RESP_LAT-deep pipeline. It is compared with Rez_in RESP_LAT
// edges after its drive edge. Mismatches are counted with saturation.
//
// Parameters:
//   NUM_VECTORS  vectors per run (1..65535)
//   RESP_LAT     clock edges from operand drive to result sample (1..8)
//   SEED         LFSR load value at run start (0 is replaced by 16'h0001)
//
// Ports:
//   Clk_in       clock, rising edge
//   Rst_n_in     asynchronous active-low reset
//   Start_in     run request, level-sampled in IDLE/DONE
//   A_out        operand A to the unit
//   B_out        operand B to the unit
//   Sel_out      operation to the unit (0 = add, 1 = subtract)
//   Rez_in       9-bit result from the unit
//   Busy_out     run in progress
//   Done_out     run finished, results valid
//   Pass_out     Done_out and zero errors
//   Err_cnt_out  mismatch count, saturating at 16'hFFFF
//
// Optional feature, macro ADDER_BIST_FIRST_ERR_EN:
//   First_err_vld_out / First_err_idx_out / First_err_got_out /
//   First_err_exp_out capture the first mismatch of a run. The capture is
//   held until the next start and cleared at reset and at start.
module adder_bist #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned RESP_LAT    = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        Clk_in,
  input  logic        Rst_n_in,
  input  logic        Start_in,
  output logic [7:0]  A_out,
  output logic [7:0]  B_out,
  output logic        Sel_out,
  input  logic [8:0]  Rez_in,
  output logic        Busy_out,
  output logic        Done_out,
  output logic        Pass_out,
  output logic [15:0] Err_cnt_out
`ifdef ADDER_BIST_FIRST_ERR_EN
  ,
  output logic        First_err_vld_out,
  output logic [15:0] First_err_idx_out,
  output logic [8:0]  First_err_got_out,
  output logic [8:0]  First_err_exp_out
`endif
);

  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned TAIL      = RESP_LAT - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // One in-flight expected result. 'last' marks the final vector of the run.
  // The final compare, not a cycle count, then ends the run.
  typedef struct packed {
    logic        vld;
    logic        last;
    logic [8:0]  exp;
`ifdef ADDER_BIST_FIRST_ERR_EN
    logic [15:0] idx;
`endif
  } slot_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] lfsr;
  logic [15:0] vec_idx;
  slot_t       pipe [RESP_LAT];
  slot_t       head;
  slot_t       tail;

  logic        start_run;
  logic        drive_en;
  logic        cmp_en;
  logic        finish;
  logic        mismatch;
  logic [15:0] drive_src;
  logic [15:0] drive_idx;
  logic [8:0]  drive_exp;
  logic [15:0] err_next;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    lfsr_step = {1'b0, x[15:1]} ^ (x[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // State register
  always_ff @(posedge Clk_in or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    drive_en   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Start_in) begin
          start_run  = 1'b1;
          drive_en   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // When the last vector is already out, this edge either holds the
        // final compare (RESP_LAT = 1) or starts draining the pipeline.
        if (vec_idx != LAST_IDX) begin
          drive_en = 1'b1;
        end else begin
          state_next = finish ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (finish) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands for the vector driven at this edge: the seed on a start,
  // otherwise the already-stepped LFSR value.
  assign drive_src = start_run ? SEED_EFF : lfsr;
  assign drive_idx = start_run ? 16'h0000 : vec_idx + 16'd1;

  always_comb begin
    drive_exp = '0;
    if (drive_idx[0]) begin
      drive_exp = {1'b0, drive_src[7:0]} - {1'b0, drive_src[15:8]};
    end else begin
      drive_exp = {1'b0, drive_src[7:0]} + {1'b0, drive_src[15:8]};
    end
  end

  always_comb begin
    head      = '0;
    head.vld  = drive_en;
    head.last = (drive_idx == LAST_IDX);
    head.exp  = drive_exp;
`ifdef ADDER_BIST_FIRST_ERR_EN
    head.idx  = drive_idx;
`endif
  end

  assign tail     = pipe[TAIL];
  assign cmp_en   = tail.vld;
  assign finish   = cmp_en && tail.last;
  assign mismatch = cmp_en && (Rez_in != tail.exp);
  assign err_next = (mismatch && (Err_cnt_out != 16'hFFFF)) ? Err_cnt_out + 16'd1
                                                             : Err_cnt_out;

  // Datapath: operand drive, LFSR, expected-result pipeline, result registers
  always_ff @(posedge Clk_in or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      lfsr        <= '0;
      vec_idx     <= '0;
      A_out       <= '0;
      B_out       <= '0;
      Sel_out     <= 1'b0;
      Busy_out    <= 1'b0;
      Done_out    <= 1'b0;
      Pass_out    <= 1'b0;
      Err_cnt_out <= '0;
      for (int unsigned i = 0; i < RESP_LAT; i++) begin
        pipe[i] <= '0;
      end
`ifdef ADDER_BIST_FIRST_ERR_EN
      First_err_vld_out <= 1'b0;
      First_err_idx_out <= '0;
      First_err_got_out <= '0;
      First_err_exp_out <= '0;
`endif
    end else begin
      pipe[0] <= head;
      for (int unsigned i = 1; i < RESP_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end

      if (drive_en) begin
        A_out   <= drive_src[7:0];
        B_out   <= drive_src[15:8];
        Sel_out <= drive_idx[0];
        lfsr    <= lfsr_step(drive_src);
        vec_idx <= drive_idx;
      end

      if (start_run) begin
        Busy_out    <= 1'b1;
        Done_out    <= 1'b0;
        Pass_out    <= 1'b0;
        Err_cnt_out <= '0;
`ifdef ADDER_BIST_FIRST_ERR_EN
        First_err_vld_out <= 1'b0;
        First_err_idx_out <= '0;
        First_err_got_out <= '0;
        First_err_exp_out <= '0;
`endif
      end else begin
        Err_cnt_out <= err_next;
        if (finish) begin
          // Pass uses err_next so the final compare is included.
          Busy_out <= 1'b0;
          Done_out <= 1'b1;
          Pass_out <= (err_next == 16'h0000);
        end
`ifdef ADDER_BIST_FIRST_ERR_EN
        if (mismatch && !First_err_vld_out) begin
          First_err_vld_out <= 1'b1;
          First_err_idx_out <= tail.idx;
          First_err_got_out <= Rez_in;
          First_err_exp_out <= tail.exp;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist.
// u0: defaults (256 vectors, RESP_LAT 1) with a combinational unit model that
//     can corrupt one chosen vector.
// u1: 4 vectors with Rez_in tied to zero.
// u2: 32 vectors, RESP_LAT 3, with a two-flop unit model. A vector driven at
//     edge k is presented at edge k+3.
module tb_adder_bist;

  localparam int unsigned N0 = 256;
  localparam int unsigned N1 = 4;
  localparam int unsigned N2 = 32;
  localparam int unsigned L2 = 3;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
  } vec_t;

  typedef struct {
    int unsigned err;
    logic        pass;
    int unsigned done_cyc;
    logic        fe_vld;
    int unsigned fe_idx;
    logic [8:0]  fe_got;
    logic [8:0]  fe_exp;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t vq0[$];
  res_t rq0[$];
  res_t rq1[$];
  res_t rq2[$];

  logic        start0, start1, start2;
  logic [7:0]  a0, b0, a1, b1, a2, b2;
  logic        sel0, sel1, sel2;
  logic [8:0]  rez0, rez1, rez2;
  logic        busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [15:0] err0, err1, err2;
  logic        fev0, fev1, fev2;
  logic [15:0] fei0, fei1, fei2;
  logic [8:0]  feg0, feg1, feg2, fee0, fee1, fee2;

  vec_t       fv0, fv2;
  logic [8:0] fmask0, fmask2;

  // ---------------- reference arithmetic ----------------
  function automatic int unit_sum(input logic [7:0] a, input logic [7:0] b,
                                  input logic sel);
    if (sel) return (int'(a) - int'(b)) & 511;
    return int'(a) + int'(b);
  endfunction

  function automatic logic [15:0] lfsr_nxt(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic vec_t vec_of(input int unsigned k);
    logic [15:0] x;
    vec_t v;
    x = 16'hACE1;
    for (int unsigned j = 0; j < k; j++) x = lfsr_nxt(x);
    v.a = x[7:0];
    v.b = x[15:8];
    v.sel = (k % 2 == 1);
    return v;
  endfunction

  function automatic res_t ref_run(input int unsigned n, input int unsigned lat,
                                   input int unsigned s, input int fidx,
                                   input logic [8:0] fmask, input bit zero);
    res_t r;
    logic [15:0] x;
    int e, g;
    r.err = 0; r.fe_vld = 1'b0; r.fe_idx = 0; r.fe_got = '0; r.fe_exp = '0;
    x = 16'hACE1;
    for (int i = 0; i < int'(n); i++) begin
      e = unit_sum(x[7:0], x[15:8], (i % 2 == 1));
      if (zero) g = 0;
      else if (i == fidx) g = e ^ int'(fmask);
      else g = e;
      if (g != e) begin
        if (r.err < 65535) r.err++;
        if (!r.fe_vld) begin
          r.fe_vld = 1'b1;
          r.fe_idx = i;
          r.fe_got = 9'(g);
          r.fe_exp = 9'(e);
        end
      end
      x = lfsr_nxt(x);
    end
    r.pass = (r.err == 0);
    r.done_cyc = s + n - 1 + lat;
    return r;
  endfunction

  // ---------------- unit models ----------------
  always_comb begin
    rez0 = 9'(unit_sum(a0, b0, sel0));
    if (fmask0 != 9'h000 && a0 == fv0.a && b0 == fv0.b && sel0 == fv0.sel)
      rez0 = rez0 ^ fmask0;
  end

  assign rez1 = 9'h000;

  logic [8:0] u2_comb, u2_q1, u2_q2;
  always_comb begin
    u2_comb = 9'(unit_sum(a2, b2, sel2));
    if (fmask2 != 9'h000 && a2 == fv2.a && b2 == fv2.b && sel2 == fv2.sel)
      u2_comb = u2_comb ^ fmask2;
  end
  always @(posedge clk) begin
    u2_q1 <= u2_comb;
    u2_q2 <= u2_q1;
  end
  assign rez2 = u2_q2;

  // ---------------- DUTs ----------------
  adder_bist #(.NUM_VECTORS(N0), .RESP_LAT(1), .SEED(16'hACE1)) u0 (
    .Clk_in(clk), .Rst_n_in(rst_n), .Start_in(start0),
    .A_out(a0), .B_out(b0), .Sel_out(sel0), .Rez_in(rez0),
    .Busy_out(busy0), .Done_out(done0), .Pass_out(pass0), .Err_cnt_out(err0)
`ifdef ADDER_BIST_FIRST_ERR_EN
    , .First_err_vld_out(fev0), .First_err_idx_out(fei0),
    .First_err_got_out(feg0), .First_err_exp_out(fee0)
`endif
  );

  adder_bist #(.NUM_VECTORS(N1), .RESP_LAT(1), .SEED(16'hACE1)) u1 (
    .Clk_in(clk), .Rst_n_in(rst_n), .Start_in(start1),
    .A_out(a1), .B_out(b1), .Sel_out(sel1), .Rez_in(rez1),
    .Busy_out(busy1), .Done_out(done1), .Pass_out(pass1), .Err_cnt_out(err1)
`ifdef ADDER_BIST_FIRST_ERR_EN
    , .First_err_vld_out(fev1), .First_err_idx_out(fei1),
    .First_err_got_out(feg1), .First_err_exp_out(fee1)
`endif
  );

  adder_bist #(.NUM_VECTORS(N2), .RESP_LAT(L2), .SEED(16'hACE1)) u2 (
    .Clk_in(clk), .Rst_n_in(rst_n), .Start_in(start2),
    .A_out(a2), .B_out(b2), .Sel_out(sel2), .Rez_in(rez2),
    .Busy_out(busy2), .Done_out(done2), .Pass_out(pass2), .Err_cnt_out(err2)
`ifdef ADDER_BIST_FIRST_ERR_EN
    , .First_err_vld_out(fev2), .First_err_idx_out(fei2),
    .First_err_got_out(feg2), .First_err_exp_out(fee2)
`endif
  );

`ifndef ADDER_BIST_FIRST_ERR_EN
  assign fev0 = 1'b0; assign fei0 = '0; assign feg0 = '0; assign fee0 = '0;
  assign fev1 = 1'b0; assign fei1 = '0; assign feg1 = '0; assign fee1 = '0;
  assign fev2 = 1'b0; assign fei2 = '0; assign feg2 = '0; assign fee2 = '0;
`endif

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  task automatic fail_evt(input string nm, input string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", nm, what);
  endtask

  task automatic chk_res(input string nm, input res_t e, input logic [15:0] err,
                         input logic pass, input logic busy, input logic fev,
                         input logic [15:0] fei, input logic [8:0] feg,
                         input logic [8:0] fee);
    chk({nm, "_err"}, 32'(err), e.err);
    chk({nm, "_pass"}, 32'(pass), 32'(e.pass));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done_cyc"}, cyc, e.done_cyc);
`ifdef ADDER_BIST_FIRST_ERR_EN
    chk({nm, "_fe_vld"}, 32'(fev), 32'(e.fe_vld));
    chk({nm, "_fe_idx"}, 32'(fei), e.fe_idx);
    chk({nm, "_fe_got"}, 32'(feg), 32'(e.fe_got));
    chk({nm, "_fe_exp"}, 32'(fee), 32'(e.fe_exp));
`endif
  endtask

  // ---------------- monitor ----------------
  logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;
  always @(negedge clk) begin
    vec_t v;
    if (busy0) begin
      if (vq0.size() == 0) begin
        fail_evt("vec_extra", "got vector while busy, required no run in progress");
      end else begin
        v = vq0.pop_front();
        chk("vec_a", 32'(a0), 32'(v.a));
        chk("vec_b", 32'(b0), 32'(v.b));
        chk("vec_sel", 32'(sel0), 32'(v.sel));
      end
    end
    if (done0 && !pd0) begin
      if (rq0.size() == 0) fail_evt("res0_unexpected", "got Done_out, required none");
      else chk_res("run0", rq0.pop_front(), err0, pass0, busy0, fev0, fei0, feg0, fee0);
    end
    if (done1 && !pd1) begin
      if (rq1.size() == 0) fail_evt("res1_unexpected", "got Done_out, required none");
      else chk_res("run1", rq1.pop_front(), err1, pass1, busy1, fev1, fei1, feg1, fee1);
    end
    if (done2 && !pd2) begin
      if (rq2.size() == 0) fail_evt("res2_unexpected", "got Done_out, required none");
      else chk_res("run2", rq2.pop_front(), err2, pass2, busy2, fev2, fei2, feg2, fee2);
    end
    pd0 = done0;
    pd1 = done1;
    pd2 = done2;
  end

  // ---------------- stimulus ----------------
  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  function automatic logic get_done(input int inst);
    case (inst)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  task automatic push_vectors(input int unsigned n);
    logic [15:0] x;
    vec_t v;
    x = 16'hACE1;
    for (int unsigned i = 0; i < n; i++) begin
      v.a = x[7:0];
      v.b = x[15:8];
      v.sel = (i % 2 == 1);
      vq0.push_back(v);
      x = lfsr_nxt(x);
    end
  endtask

  task automatic wait_done(input int inst, input int unsigned lim);
    for (int unsigned k = 0; k < lim; k++) begin
      at_edge();
      if (get_done(inst)) return;
    end
    fail_evt("done_timeout", "got no Done_out, required Done_out within cycle budget");
  endtask

  task automatic run(input int inst, input int fidx, input logic [8:0] fmask,
                     input bit hold, input bit chk_v0);
    int unsigned s, n, lat;
    res_t r;
    n   = (inst == 0) ? N0 : (inst == 1) ? N1 : N2;
    lat = (inst == 2) ? L2 : 1;
    if (inst == 0) begin
      fmask0 = (fidx >= 0) ? fmask : 9'h000;
      if (fidx >= 0) fv0 = vec_of(fidx);
    end
    if (inst == 2) begin
      fmask2 = (fidx >= 0) ? fmask : 9'h000;
      if (fidx >= 0) fv2 = vec_of(fidx);
    end
    repeat ($urandom_range(0, 3)) at_edge();
    at_edge();
    s = cyc + 1;
    r = ref_run(n, lat, s, fidx, fmask, inst == 1);
    case (inst)
      0: begin rq0.push_back(r); push_vectors(n); end
      1: rq1.push_back(r);
      default: rq2.push_back(r);
    endcase
    set_start(inst, 1'b1);
    at_edge();
    if (chk_v0) begin
      chk("vec0_a", 32'(a0), 32'h0E1);
      chk("vec0_b", 32'(b0), 32'h0AC);
      chk("vec0_sel", 32'(sel0), 32'h0);
      chk("vec0_busy", 32'(busy0), 32'h1);
    end
    if (!hold) set_start(inst, 1'b0);
    wait_done(inst, n + lat + 10);
    set_start(inst, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned ri;
    rst_n  = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    fmask0 = 9'h000; fmask2 = 9'h000;
    fv0 = vec_of(0); fv2 = vec_of(0);
    #12;
    chk("rst_a", 32'(a0), 0);       chk("rst_b", 32'(b0), 0);
    chk("rst_sel", 32'(sel0), 0);   chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0); chk("rst_pass", 32'(pass0), 0);
    chk("rst_err", 32'(err0), 0);   chk("rst_busy2", 32'(busy2), 0);
    at_edge();
    rst_n = 1'b1;
    at_edge();

    // Clean runs: pulse, start held high, pulse again (identical results)
    run(0, -1, 9'h000, 1'b0, 1'b1);
    run(0, -1, 9'h000, 1'b1, 1'b0);
    run(0, -1, 9'h000, 1'b0, 1'b1);

    // Bit 8 flipped on vector 5 only
    run(0, 5, 9'h100, 1'b0, 1'b0);

    // Reset in the middle of a run
    at_edge();
    push_vectors(N0);
    fmask0 = 9'h000;
    start0 = 1'b1;
    at_edge();
    start0 = 1'b0;
    repeat (100) at_edge();
    chk("abort_busy_before", 32'(busy0), 1);
    rst_n = 1'b0;
    vq0.delete();
    #1;
    chk("abort_a", 32'(a0), 0);       chk("abort_b", 32'(b0), 0);
    chk("abort_sel", 32'(sel0), 0);   chk("abort_busy", 32'(busy0), 0);
    chk("abort_done", 32'(done0), 0); chk("abort_pass", 32'(pass0), 0);
    chk("abort_err", 32'(err0), 0);
`ifdef ADDER_BIST_FIRST_ERR_EN
    chk("abort_fe_vld", 32'(fev0), 0);
`endif
    at_edge();
    at_edge();
    rst_n = 1'b1;
    repeat (3) at_edge();
    chk("idle_busy", 32'(busy0), 0);
    chk("idle_done", 32'(done0), 0);
    run(0, -1, 9'h000, 1'b0, 1'b1);

    // Result tied to zero, 4 vectors
    run(1, -1, 9'h000, 1'b0, 1'b0);

    // RESP_LAT 3: clean, then a random corrupted vector
    run(2, -1, 9'h000, 1'b0, 1'b0);
    ri = $urandom_range(0, N2 - 1);
    run(2, int'(ri), 9'($urandom_range(1, 511)), 1'b0, 1'b0);

    // Random corrupted vector on the default instance
    ri = $urandom_range(0, N0 - 1);
    run(0, int'(ri), 9'($urandom_range(1, 511)), 1'b0, 1'b0);

    repeat (4) at_edge();
    chk("vq0_left", vq0.size(), 0);
    chk("rq0_left", rq0.size(), 0);
    chk("rq1_left", rq1.size(), 0);
    chk("rq2_left", rq2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
- Clocked built-in self-test driver/checker for the combinational 8-bit add/subtract unit (ports A_in, B_in, Sel_in, Rez_out).
- Sits on the opposite side of that unit's interface: generates operands from an LFSR and drives them into the unit.
- Samples the unit's 9-bit result after a fixed latency, compares it against an internal reference model, and reports error count and pass/fail.
- Used for on-chip and bring-up testing of the arithmetic unit.

Parameters:
- NUM_VECTORS, 256, vectors per run (1..65535).
- RESP_LAT, 1, clock edges from operand drive to result sample (1..8).
- SEED, 16'hACE1, LFSR load value at run start; value 0 is replaced by 16'h0001.

Ports:
- Clk_in  input  1  clock, rising edge.
- Rst_n_in  input  1  asynchronous active-low reset.
- Start_in  input  1  run request, level-sampled.
- A_out  output  8  operand A to the unit's A_in.
- B_out  output  8  operand B to the unit's B_in.
- Sel_out  output  1  operation to the unit's Sel_in: 0 = add, 1 = subtract.
- Rez_in  input  9  result from the unit's Rez_out.
- Busy_out  output  1  run in progress.
- Done_out  output  1  run finished; results valid.
- Pass_out  output  1  Done_out and zero errors.
- Err_cnt_out  output  16  mismatch count, saturates at 16'hFFFF.

Behaviour:
- Reset: Rst_n_in low asynchronously clears every output and all internal state, and forces IDLE. Reset mid-run aborts the run with no partial results retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE with Start_in=1 at edge S:
  - Load LFSR with SEED; vector index = 0.
  - Clear Err_cnt_out, Done_out and Pass_out.
  - Drive vector 0 on A_out/B_out/Sel_out; Busy_out=1; go to RUN.
- Start_in is ignored in RUN and DRAIN.
- Vector i (i = 0..NUM_VECTORS-1):
  - Driven at edge S+i.
  - A_out = lfsr[7:0], B_out = lfsr[15:8], Sel_out = i[0].
  - LFSR then steps (Galois, right shift; if the shifted-out bit is 1, XOR with 16'hB400).
- RUN to DRAIN: after vector NUM_VECTORS-1 is driven. Outputs hold the last vector during DRAIN.
- Expected-result model:
  - Sel=0: {1'b0,A} + {1'b0,B}.
  - Sel=1: ({1'b0,A} - {1'b0,B}) mod 512.
  - Each expected value is pushed with a valid bit into a RESP_LAT-deep pipeline at its drive edge.
- Compare: at edge S+i+RESP_LAT, Rez_in is compared with expected(i). On mismatch Err_cnt_out increments, saturating at 16'hFFFF.
- Completion at edge S+NUM_VECTORS-1+RESP_LAT (the last compare):
  - State goes to DONE; Busy_out=0, Done_out=1.
  - Pass_out = (final error count == 0); the final compare is included.
- DONE holds all result outputs until a new Start_in or reset.
- NUM_VECTORS=1: RUN lasts one cycle.
- DRAIN lasts RESP_LAT-1 cycles; with RESP_LAT=1, RUN goes directly to DONE at the last compare edge.

Optional Feature:
- Macro: ADDER_BIST_FIRST_ERR_EN.
- Defined: adds output ports First_err_vld_out (1), First_err_idx_out (16), First_err_got_out (9) and First_err_exp_out (9).
  - These capture the index, received value and expected value of the first mismatch in a run.
  - The capture is held until the next Start_in; all four ports are cleared at reset and at Start_in.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Correct unit model, defaults, Start pulse at S: vector 0 is A_out=8'hE1, B_out=8'hAC, Sel_out=0, compared against 9'h18D. Done_out rises at S+256, Err_cnt_out=0, Pass_out=1.
- Model flips Rez bit 8 on vector index 5 only: Err_cnt_out=1, Pass_out=0. With ADDER_BIST_FIRST_ERR_EN: First_err_idx_out=5, First_err_got_out = exp ^ 9'h100.
- Rez_in tied to 9'h000, NUM_VECTORS=4: Err_cnt_out equals the number of the 4 vectors with nonzero expected value (bench computes); Pass_out=0.
- Start_in held high throughout the run: the run is not restarted mid-way; the result is identical to a single pulse. A second run after DONE reproduces the identical vector sequence and result.
- Rst_n_in low at S+100 in RUN: all outputs are 0 in the same cycle, the FSM returns to IDLE, and a subsequent Start gives a clean full run with Pass_out=1.
- RESP_LAT=3 with a model that registers the result for 3 cycles: Pass_out=1 and Done_out rises at S+NUM_VECTORS+2.
